// File: rtl/frame_sync_tracker.sv
// frame_sync_tracker: I2S / LJ / DSP-TDM frame and slot position tracker.
// All state advances on the falling edge of the bit clock.
module frame_sync_tracker #(
  parameter int CH_MAX = 8,
  parameter int SW = $clog2(CH_MAX)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          ws,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [SW:0]   num_ch,
  input  logic [4:0]    slot_len_m1,
  output logic [1:0]    state,
  output logic [SW-1:0] slot,
  output logic [4:0]    bit_cnt,
  output logic          slot_active,
  output logic          frame_start,
  output logic          slot_start,
  output logic          sync_err,
  output logic [7:0]    err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HUNT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] M_I2S  = 2'd0;
  localparam logic [1:0] M_DSP  = 2'd2;
  localparam logic [1:0] M_RSV  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [4:0]    bit_q, bit_d;
  logic          fs_q, fs_d;
  logic          ss_q, ss_d;
  logic          se_q, se_d;
  logic [7:0]    err_q, err_d;
  logic          ws_q;
  logic [1:0]    mode_q, mode_d;
  logic [SW:0]   nch_q, nch_d;
  logic [4:0]    slen_q, slen_d;

  logic          run, go, dsp, stereo;
  logic          e, m, bit_end, frame_end;
  logic [1:0]    cur_mode;
  logic [SW-1:0] last_slot;

  always_ff @(negedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      bit_q   <= '0;
      fs_q    <= 1'b0;
      ss_q    <= 1'b0;
      se_q    <= 1'b0;
      err_q   <= '0;
      ws_q    <= 1'b0;
      mode_q  <= '0;
      nch_q   <= '0;
      slen_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      fs_q    <= fs_d;
      ss_q    <= ss_d;
      se_q    <= se_d;
      err_q   <= err_d;
      ws_q    <= ws;
      mode_q  <= mode_d;
      nch_q   <= nch_d;
      slen_q  <= slen_d;
    end
  end

  // Live inputs steer edge detection until the frame format is frozen in RUN.
  always_comb begin
    run       = state_q == S_RUN;
    go        = en && (mode != M_RSV);
    cur_mode  = run ? mode_q : mode;
    dsp       = cur_mode == M_DSP;
    stereo    = !dsp && (cur_mode != M_RSV);
    e         = (cur_mode == M_I2S) ? (ws_q & ~ws) : (~ws_q & ws);
    m         = stereo & (ws_q ^ ws) & ~e;
    last_slot = dsp ? SW'(nch_q - 1'b1) : SW'(1);
    bit_end   = bit_q == slen_q;
    frame_end = bit_end && (slot_q == last_slot);
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    bit_d   = bit_q;
    fs_d    = 1'b0;
    ss_d    = 1'b0;
    se_d    = 1'b0;
    mode_d  = run ? mode_q : mode;
    nch_d   = run ? nch_q : num_ch;
    slen_d  = run ? slen_q : slot_len_m1;
    unique case (1'b1)
      !go: begin
        state_d = S_IDLE;
        slot_d  = '0;
        bit_d   = '0;
      end
      go && state_q == S_IDLE: state_d = S_HUNT;
      go && state_q == S_HUNT: begin
        if (e) begin
          state_d = S_RUN;
          slot_d  = '0;
          bit_d   = '0;
          fs_d    = 1'b1;
          ss_d    = 1'b1;
        end
      end
      go && run: begin
        if (e) begin
          se_d   = !frame_end;
          slot_d = '0;
          bit_d  = '0;
          fs_d   = 1'b1;
          ss_d   = 1'b1;
        end else if (frame_end) begin
          state_d = S_HUNT;
          slot_d  = '0;
          bit_d   = '0;
        end else if (stereo && bit_end && slot_q == '0) begin
          se_d   = !m;
          slot_d = SW'(1);
          bit_d  = '0;
          ss_d   = 1'b1;
        end else if (m && slot_q == '0) begin
          se_d   = 1'b1;
          slot_d = SW'(1);
          bit_d  = '0;
          ss_d   = 1'b1;
        end else begin
          se_d = m;
          if (bit_end) begin
            bit_d  = '0;
            slot_d = slot_q + 1'b1;
            ss_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        slot_d  = '0;
        bit_d   = '0;
      end
    endcase
    err_d = (se_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // A mono I2S/LJ stream carries data only in the left slot.
  always_comb begin
    slot_active = 1'b0;
    if (state_q == S_RUN) begin
      if (mode_q == M_DSP)
        slot_active = {1'b0, slot_q} < nch_q;
      else
        slot_active = (nch_q >= (SW+1)'(2)) || (slot_q == '0);
    end
    state       = state_q;
    slot        = slot_q;
    bit_cnt     = bit_q;
    frame_start = fs_q;
    slot_start  = ss_q;
    sync_err    = se_q;
    err_cnt     = err_q;
  end

endmodule

// File: tb/tb_frame_sync_tracker.sv
// tb_frame_sync_tracker: frame-position reference model feeding a scoreboard,
// plus directed checks on lock, mid-frame errors, mono, saturation, reset.
module tb_frame_sync_tracker;

  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          ws = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [SW:0]   num_ch = 4'd2;
  logic [4:0]    slot_len_m1 = 5'd15;
  logic [1:0]    state;
  logic [SW-1:0] slot;
  logic [4:0]    bit_cnt;
  logic          slot_active, frame_start, slot_start, sync_err;
  logic [7:0]    err_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  int m_st, m_pos, m_mode, m_nch, m_slen, m_err;
  bit m_wsq, m_fs, m_ss, m_se;

  always #5 clk = ~clk;

  frame_sync_tracker dut (
    .clk(clk), .rst_(rst_), .ws(ws), .en(en), .mode(mode),
    .num_ch(num_ch), .slot_len_m1(slot_len_m1), .state(state),
    .slot(slot), .bit_cnt(bit_cnt), .slot_active(slot_active),
    .frame_start(frame_start), .slot_start(slot_start),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {10'b0, state, slot, bit_cnt, slot_active,
            frame_start, slot_start, sync_err, err_cnt};
  endfunction

  function automatic logic [31:0] model_vec();
    int l = m_slen + 1;
    int s = m_pos / l;
    int b = m_pos % l;
    logic act;
    act = (m_st == 2) &&
          ((m_mode == 2) ? (s < m_nch) : (m_nch >= 2 || s == 0));
    return {10'b0, 2'(m_st), 3'(s), 5'(b), act,
            m_fs, m_ss, m_se, 8'(m_err)};
  endfunction

  // Position-in-frame model: pos runs 0..FL-1.
  task automatic model_step();
    int md, l, fl, p;
    bit e, mm, st, dsp;
    m_fs = 0; m_ss = 0; m_se = 0;
    if (!rst_) begin
      m_st = 0; m_pos = 0; m_wsq = 0;
      m_mode = 0; m_nch = 0; m_slen = 0; m_err = 0;
      return;
    end
    md  = (m_st == 2) ? m_mode : int'(mode);
    dsp = (md == 2);
    st  = (md < 2);
    e   = (md == 0) ? (m_wsq && !ws) : (!m_wsq && ws);
    mm  = st && (m_wsq != ws) && !e;
    if (m_st != 2) begin
      m_mode = mode; m_nch = num_ch; m_slen = slot_len_m1;
    end
    if (!en || mode == 2'd3) begin
      m_st = 0; m_pos = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (e) begin m_st = 2; m_pos = 0; m_fs = 1; m_ss = 1; end
    end else begin
      l  = m_slen + 1;
      fl = dsp ? m_nch * l : 2 * l;
      p  = m_pos;
      if (e) begin
        m_se = (p != fl - 1); m_pos = 0; m_fs = 1; m_ss = 1;
      end else if (p == fl - 1) begin
        m_st = 1; m_pos = 0;
      end else if (st && p == l - 1) begin
        m_se = !mm; m_pos = l; m_ss = 1;
      end else if (mm) begin
        m_se = 1;
        if (p < l) begin m_pos = l; m_ss = 1; end
        else m_pos = p + 1;
      end else begin
        m_pos = p + 1;
        m_ss = (m_pos % l) == 0;
      end
    end
    if (m_se && m_err < 255) m_err++;
    m_wsq = ws;
  endtask

  always @(negedge clk) begin
    model_step();
    exp_q.push_back(model_vec());
    #1;
    chk("cycle", dut_vec(), exp_q.pop_front());
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(posedge clk);
      ws = v;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  initial begin
    int fs_n, se_n, act_n;
    #2 chk("reset", dut_vec(), 32'd0);
    repeat (3) @(posedge clk);
    rst_ = 1'b1; en = 1'b1; mode = 2'd0; num_ch = 4'd2; slot_len_m1 = 5'd15;
    ws = 1'b1;
    drive(1'b1, 10);
    chk("i2s_hunt", 32'(state), 32'd1);

    fs_n = 0; se_n = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 32; i++) begin
        @(posedge clk);
        ws = (i < 16) ? 1'b0 : 1'b1;
        sample();
        fs_n += int'(frame_start);
        se_n += int'(sync_err);
        if (f == 1 && i == 16) chk("i2s_slot1", {slot, bit_cnt}, {3'd1, 5'd0});
        if (f == 2 && i == 15) chk("i2s_slot0", {slot, bit_cnt}, {3'd0, 5'd15});
      end
    chk("i2s_fs", 32'(fs_n), 32'd3);
    chk("i2s_se", 32'(se_n), 32'd0);
    drive(1'b1, 40);
    chk("i2s_stop", 32'(state), 32'd1);

    mode = 2'd2; num_ch = 4'd6; slot_len_m1 = 5'd7;
    drive(1'b0, 5);
    act_n = 0;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 48; i++) begin
        @(posedge clk);
        ws = (i == 0);
        sample();
        act_n += int'(slot_active);
        if (p == 1 && i == 47) chk("dsp_last", {slot, bit_cnt}, {3'd5, 5'd7});
        if (p == 2 && i == 27) chk("dsp_mid", {slot, bit_cnt}, {3'd3, 5'd3});
      end
    chk("dsp_act", 32'(act_n), 32'd144);
    @(posedge clk);
    ws = 1'b0;
    sample();
    chk("dsp_hunt", {state, sync_err, err_cnt}, {2'd1, 1'b0, 8'd0});

    mode = 2'd1; num_ch = 4'd2; slot_len_m1 = 5'd15;
    drive(1'b0, 3);
    drive(1'b1, 16);
    drive(1'b0, 16);
    drive(1'b1, 12);
    @(posedge clk);
    ws = 1'b0;
    sample();
    chk("lj_early", {sync_err, err_cnt, slot, bit_cnt},
        {1'b1, 8'd1, 3'd1, 5'd0});
    drive(1'b0, 30);

    mode = 2'd0; num_ch = 4'd1;
    drive(1'b1, 4);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 32; i++) begin
        @(posedge clk);
        ws = (i < 16) ? 1'b0 : 1'b1;
        if (f == 0 && i == 20) num_ch = 4'd2;
        sample();
        if (f == 1 && i == 5) chk("mono_l", 32'(slot_active), 32'd1);
        if (f == 1 && i == 20) chk("mono_r", {slot, slot_active}, {3'd1, 1'b0});
      end
    drive(1'b1, 40);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      ws = (i < 16) ? 1'b0 : 1'b1;
      sample();
      if (i == 20) chk("stereo_r", {slot, slot_active}, {3'd1, 1'b1});
    end
    drive(1'b1, 40);

    @(posedge clk);
    ws = 1'b0; en = 1'b0;
    sample();
    chk("en_wins", {state, frame_start}, {2'd0, 1'b0});
    en = 1'b1;
    drive(1'b0, 3);
    mode = 2'd3;
    sample();
    sample();
    chk("mode_rsv", 32'(state), 32'd0);

    mode = 2'd2; num_ch = 4'd6; slot_len_m1 = 5'd7;
    drive(1'b0, 3);
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 1);
      drive(1'b0, 9);
    end
    chk("sat", 32'(err_cnt), 32'd255);
    drive(1'b1, 1);
    drive(1'b0, 5);
    @(posedge clk);
    rst_ = 1'b0;
    #1 chk("rst_async", dut_vec(), 32'd0);
    repeat (2) @(posedge clk);
    rst_ = 1'b1;
    drive(1'b0, 10);
    chk("rst_hunt", {state, err_cnt}, {2'd1, 8'd0});
    drive(1'b1, 1);
    sample();
    chk("relock", {state, frame_start, slot, bit_cnt},
        {2'd2, 1'b1, 3'd0, 5'd0});
    drive(1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/frame_sync_tracker.md
FRAME_SYNC_TRACKER -- requirements
Module: frame_sync_tracker

Interface
REQ-001 Parameter CH_MAX, default 8: maximum slots per frame; legal values are 2..16.
REQ-002 Parameter SW, default $clog2(CH_MAX): width of the slot index.
REQ-003 Port clk  input  1: bit clock; all sequential logic SHALL act on its falling edge.
REQ-004 Port rst_  input  1: asynchronous, active-low reset.
REQ-005 Port ws  input  1: word-select / frame-sync from the external master.
REQ-006 Port en  input  1: tracker enable.
REQ-007 Port mode  input  2: frame format; 0=I2S, 1=left-justified (LJ), 2=DSP short-pulse TDM, 3=reserved.
REQ-008 Port num_ch  input  SW+1: active slots per frame; legal range is 1..CH_MAX.
REQ-009 Port slot_len_m1  input  5: slot length in bits minus one; legal range is 7..31.
REQ-010 Port state  output  2: tracker state; 0=IDLE, 1=HUNT, 2=RUN.
REQ-011 Port slot  output  SW: current slot index.
REQ-012 Port bit_cnt  output  5: bit position within the current slot; 0 is the MSB slot bit.
REQ-013 Port slot_active  output  1: high when the current slot carries data.
REQ-014 Port frame_start, slot_start, sync_err  output  1 each: single-cycle pulses.
REQ-015 Port err_cnt  output  8: saturating count of sync errors.

Function
REQ-016 A frame edge E SHALL be evaluated at each falling edge as a combinational compare of ws against ws_q, the previous sample of ws.
- I2S: E = ws_q & ~ws
- LJ and DSP: E = ~ws_q & ws
REQ-017 For I2S and LJ, the mid-frame toggle M SHALL be the opposite transition of E.
REQ-018 Configuration (mode, num_ch, slot_len_m1) SHALL be latched on every cycle in IDLE or HUNT and held constant while in RUN.
REQ-019 Frame length FL SHALL be:
- 2*(slot_len_m1+1) for I2S and LJ;
- num_ch*(slot_len_m1+1) for DSP.
REQ-020 State IDLE:
- entered whenever en=0, or mode=3;
- outputs are held at their reset values, except err_cnt, which holds its value.
REQ-021 State HUNT: entered from IDLE when en=1 and mode!=3; the tracker waits for E.
REQ-022 On E in HUNT, in the same cycle:
- state -> RUN, slot=0, bit_cnt=0;
- frame_start=1 and slot_start=1.
REQ-023 In RUN, bit_cnt SHALL increment every cycle.
- When bit_cnt=slot_len_m1, bit_cnt wraps to 0, slot increments and slot_start pulses.
- For I2S and LJ, slot wraps after slot 1.
- For DSP, slot wraps after slot num_ch-1.
REQ-024 At the expected frame boundary (last bit of the last slot just completed):
- if E is present, a new frame starts with slot=0 and frame_start=1;
- if E is absent, state -> HUNT with no error.
This is the stop/idle detection.
REQ-025 E at any cycle other than the expected frame boundary SHALL:
- pulse sync_err;
- increment err_cnt;
- restart the frame exactly as REQ-022.
REQ-026 For I2S and LJ, a mismatched mid-frame toggle is an error: M absent at the slot-1 boundary, or M present at any other cycle.
- sync_err SHALL pulse and err_cnt SHALL increment.
- If M occurs early, slot jumps to 1 with bit_cnt=0.
- If M is missing, counting continues normally.
REQ-027 For DSP, a ws level still high two cycles after E SHALL NOT count as an error; only the rising edge is significant.
REQ-028 slot_active SHALL be high when:
- I2S or LJ: num_ch>=2, or slot=0 (mono, where the right slot carries no data);
- DSP: slot<num_ch.
slot_active SHALL be low outside RUN.
REQ-029 err_cnt SHALL saturate at 255 and clear only on reset.
REQ-030 When E and en=0 occur in the same cycle, en=0 SHALL win: state -> IDLE.

Reset
REQ-031 On rst_=0, immediately and asynchronously:
- state=IDLE, slot=0, bit_cnt=0, slot_active=0;
- frame_start=0, slot_start=0, sync_err=0;
- err_cnt=0, ws_q=0, all latched configuration=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; after release the tracker SHALL resynchronise via HUNT only.

Verification
REQ-033 I2S stereo, slot_len_m1=15, 32-cycle ws period, 3 frames -> frame_start every 32 cycles, slot 0/1 alternates every 16 cycles, sync_err never pulses.
REQ-034 DSP, num_ch=6, slot_len_m1=7, 1-cycle pulse every 48 cycles -> slot 0..5 with bit_cnt 0..7 each, slot_active=1 throughout; then pulses stop -> state returns to HUNT at cycle 48 with no error.
REQ-035 LJ stereo, ws toggles 4 cycles early mid-frame -> sync_err pulse, err_cnt=1, slot=1 and bit_cnt=0 in the same cycle.
REQ-036 I2S mono (num_ch=1) -> slot_active=1 for slot 0 only; num_ch changed to 2 during RUN -> no effect until the next HUNT.
REQ-037 300 early frame edges -> err_cnt saturates at 255; rst_ pulse mid-frame -> all outputs return to reset values, and the tracker locks only on the next E.
